// File: rtl/udp_rx_pkg.sv
// -----------------------------------------------------------------------------
// udp_rx_pkg
// Shared definitions for the UDP receive frame buffer:
//   WORD_W            payload word width
//   rd_state_t        replay FSM states (IDLE, LOAD, STREAM)
//   keep_from_tail()  last-word byte enables from (byte count mod 4)
//   words_from_bytes() ceil(bytes / 4)
// -----------------------------------------------------------------------------
package udp_rx_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } rd_state_t;

  // Byte enables for the final word; bit 3 covers the first byte [31:24].
  function automatic logic [3:0] keep_from_tail(input logic [1:0] tail);
    case (tail)
      2'd1:    return 4'b1000;
      2'd2:    return 4'b1100;
      2'd3:    return 4'b1110;
      default: return 4'b1111;
    endcase
  endfunction

  // Number of 32-bit words needed to carry a frame of 'num' bytes.
  function automatic logic [15:0] words_from_bytes(input logic [15:0] num);
    return 16'(({1'b0, num} + 17'd3) >> 2);
  endfunction

endpackage

// File: rtl/udp_rx_sdp_ram.sv
// -----------------------------------------------------------------------------
// udp_rx_sdp_ram
// Simple dual-port payload RAM, one write port and one registered read port.
//   sys_clk  clock
//   wr_en    write strobe; wr_addr / wr_data
//   rd_en    read strobe; rd_data updates one cycle after rd_addr is sampled
//            and holds its value while rd_en is low
// -----------------------------------------------------------------------------
module udp_rx_sdp_ram
  import udp_rx_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              sys_clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [1 << ADDR_W];

  // NOTE: the array and its read register have no reset so they map onto
  // block RAM; validity is tracked by reset flops in the controller instead.
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/udp_rx_frame_buf.sv
// -----------------------------------------------------------------------------
// udp_rx_frame_buf
// Collects parser payload words into a circular RAM, commits a frame only when
// it ends cleanly (rolling back errored / overflowed / inconsistent frames) and
// replays committed frames on a valid/ready stream.
//   sys_clk, sys_rst         clock, asynchronous active-high reset
//   rec_data_en, rec_data    payload word strobe and word (first byte [31:24])
//   rec_end, rec_data_num    end-of-frame strobe and frame byte count
//   err_flag                 parser error level
//   m_valid/m_data/m_last/m_keep, m_ready   output stream
//   frm_ok_cnt, frm_drop_cnt committed / dropped frame counters (wrap)
// -----------------------------------------------------------------------------
module udp_rx_frame_buf
  import udp_rx_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int DESC_AW = 3
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        rec_data_en,
  input  logic [31:0] rec_data,
  input  logic        rec_end,
  input  logic [15:0] rec_data_num,
  input  logic        err_flag,
  output logic        m_valid,
  output logic [31:0] m_data,
  output logic        m_last,
  output logic [3:0]  m_keep,
  input  logic        m_ready,
  output logic [15:0] frm_ok_cnt,
  output logic [15:0] frm_drop_cnt
);

  localparam int                DESC_DEPTH = 1 << DESC_AW;
  localparam logic [ADDR_W:0]   BUF_WORDS  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [DESC_AW:0]  DESC_SLOTS = {1'b1, {DESC_AW{1'b0}}};

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  logic [ADDR_W:0] wr_ptr, wr_cmt, rd_ptr, rd_addr;
  logic [ADDR_W:0] used, wr_ptr_nxt;
  logic            buf_full, wr_word;
  logic            in_frame, bad, bad_now;
  logic [15:0]     wcnt, wcnt_now;
  logic            desc_full, accept;
  logic [DESC_AW:0] frm_pend;

  // Uncommitted words count as occupied: space is measured from the reader.
  assign used     = wr_ptr - rd_ptr;
  assign buf_full = (used == BUF_WORDS);
  assign wr_word  = rec_data_en & ~buf_full;
  assign wr_ptr_nxt = wr_ptr + (ADDR_W + 1)'(wr_word);

  // A new frame starts from clean per-frame state even if stale values linger.
  assign wcnt_now = (in_frame ? wcnt : 16'd0) + {15'd0, rec_data_en};
  assign bad_now  = (in_frame & bad)
                  | (err_flag & (rec_data_en | rec_end))
                  | (rec_data_en & buf_full);

  // A descriptor slot is held until that frame's last word is handshaked, so
  // the slot count bounds every committed frame not yet fully replayed.
  assign desc_full = (frm_pend == DESC_SLOTS);

  assign accept = rec_end & ~bad_now & ~desc_full
                & (rec_data_num != 16'd0)
                & (wcnt_now == words_from_bytes(rec_data_num));

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr       <= '0;
      wr_cmt       <= '0;
      in_frame     <= 1'b0;
      bad          <= 1'b0;
      wcnt         <= '0;
      frm_ok_cnt   <= '0;
      frm_drop_cnt <= '0;
    end else if (rec_end) begin
      in_frame <= 1'b0;
      bad      <= 1'b0;
      wcnt     <= '0;
      if (accept) begin
        wr_ptr     <= wr_ptr_nxt;
        wr_cmt     <= wr_ptr_nxt;
        frm_ok_cnt <= frm_ok_cnt + 16'd1;
      end else begin
        wr_ptr       <= wr_cmt;
        frm_drop_cnt <= frm_drop_cnt + 16'd1;
      end
    end else if (rec_data_en) begin
      in_frame <= 1'b1;
      bad      <= bad_now;
      wcnt     <= wcnt_now;
      wr_ptr   <= wr_ptr_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Descriptor FIFO (byte count per committed frame)
  // ---------------------------------------------------------------------------
  logic [15:0]      desc_mem [DESC_DEPTH];
  logic [DESC_AW:0] desc_wp, desc_rp;
  logic             desc_empty, desc_pop;
  logic [15:0]      head_num, head_words;

  rd_state_t rd_state, rd_state_nxt;

  assign desc_empty = (desc_wp == desc_rp);
  assign desc_pop   = (rd_state == LOAD);
  assign head_num   = desc_mem[desc_rp[DESC_AW-1:0]];
  assign head_words = words_from_bytes(head_num);

  always_ff @(posedge sys_clk) begin
    if (accept) desc_mem[desc_wp[DESC_AW-1:0]] <= rec_data_num;
  end

  // ---------------------------------------------------------------------------
  // Read side: issue stage (FSM + RAM read), RAM output stage (s1), output
  // register (m_*). Each stage advances when the stage after it can take data,
  // giving one word per cycle and a stable output while stalled.
  // ---------------------------------------------------------------------------
  logic [15:0] iss_rem, cur_rem;
  logic [1:0]  tail, cur_tail;
  logic        s1_v, s1_last;
  logic [3:0]  s1_keep;
  logic        s2_load, s1_en;
  logic        want_issue, issue, issue_last, all_issued;
  logic        m_hs, last_hs;
  logic [WORD_W-1:0] ram_q;

  assign m_hs    = m_valid & m_ready;
  assign last_hs = m_hs & m_last;
  assign s2_load = ~m_valid | m_ready;
  assign s1_en   = ~s1_v | s2_load;

  // LOAD issues the first word straight from the popped descriptor.
  assign cur_rem    = (rd_state == LOAD) ? head_words : iss_rem;
  assign cur_tail   = (rd_state == LOAD) ? head_num[1:0] : tail;
  assign want_issue = (rd_state == LOAD) | ((rd_state == STREAM) & (iss_rem != 16'd0));
  assign issue      = want_issue & s1_en;
  assign issue_last = issue & (cur_rem == 16'd1);
  assign all_issued = (cur_rem == 16'd0) | issue_last;

  // The FSM tracks the issue side; words already in flight drain on their own,
  // so the next frame is loaded as soon as the current one is fully issued.
  always_comb begin
    // NOTE: defaulting before the case keeps every path assigned, so no latch.
    rd_state_nxt = rd_state;
    case (rd_state)
      IDLE:    if (!desc_empty) rd_state_nxt = LOAD;
      LOAD:    rd_state_nxt = STREAM;
      STREAM:  if (all_issued) rd_state_nxt = desc_empty ? IDLE : LOAD;
      default: rd_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      desc_wp  <= '0;
      desc_rp  <= '0;
      frm_pend <= '0;
      rd_state <= IDLE;
      iss_rem  <= '0;
      tail     <= '0;
      rd_addr  <= '0;
    end else begin
      if (accept)   desc_wp <= desc_wp + 1'b1;
      if (desc_pop) desc_rp <= desc_rp + 1'b1;
      case ({accept, last_hs})
        2'b10:   frm_pend <= frm_pend + 1'b1;
        2'b01:   frm_pend <= frm_pend - 1'b1;
        default: frm_pend <= frm_pend;
      endcase
      rd_state <= rd_state_nxt;
      if (rd_state == LOAD) tail <= cur_tail;
      if (want_issue) iss_rem <= cur_rem - {15'd0, issue};
      if (issue) rd_addr <= rd_addr + 1'b1;
    end
  end

  udp_rx_sdp_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .sys_clk (sys_clk),
    .wr_en   (wr_word),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (rec_data),
    .rd_en   (issue),
    .rd_addr (rd_addr[ADDR_W-1:0]),
    .rd_data (ram_q)
  );

  // Sideband for the word currently on the RAM output.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      s1_v    <= 1'b0;
      s1_last <= 1'b0;
      s1_keep <= 4'b0000;
    end else if (s1_en) begin
      s1_v    <= issue;
      s1_last <= issue_last;
      s1_keep <= issue_last ? keep_from_tail(cur_tail) : 4'b1111;
    end
  end

  // Output register; rd_ptr frees a RAM word only once it has been accepted.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_keep  <= 4'b0000;
      m_data  <= '0;
      rd_ptr  <= '0;
    end else begin
      if (s2_load) begin
        m_valid <= s1_v;
        m_last  <= s1_last;
        m_keep  <= s1_keep;
        if (s1_v) m_data <= ram_q;
      end
      if (m_hs) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_udp_rx_frame_buf.sv
// -----------------------------------------------------------------------------
// tb_udp_rx_frame_buf
// Directed bench for udp_rx_frame_buf with a 16-word payload RAM and an
// 8-entry descriptor FIFO. Expected output words come from a queue filled as
// frames are sent; stimulus is driven and outputs are sampled on the falling
// edge.
// -----------------------------------------------------------------------------
module tb_udp_rx_frame_buf;

  localparam int ADDR_W  = 4;
  localparam int DESC_AW = 3;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        rec_data_en;
  logic [31:0] rec_data;
  logic        rec_end;
  logic [15:0] rec_data_num;
  logic        err_flag;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_last;
  logic [3:0]  m_keep;
  logic        m_ready;
  logic [15:0] frm_ok_cnt;
  logic [15:0] frm_drop_cnt;

  always #5 sys_clk = ~sys_clk;

  udp_rx_frame_buf #(
    .ADDR_W  (ADDR_W),
    .DESC_AW (DESC_AW)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .rec_data_en  (rec_data_en),
    .rec_data     (rec_data),
    .rec_end      (rec_end),
    .rec_data_num (rec_data_num),
    .err_flag     (err_flag),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_last       (m_last),
    .m_keep       (m_keep),
    .m_ready      (m_ready),
    .frm_ok_cnt   (frm_ok_cnt),
    .frm_drop_cnt (frm_drop_cnt)
  );

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic [3:0]  k;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Last-word enables: the first 'tail' bytes from the top, all four if 0.
  function automatic logic [3:0] model_keep(input int nbytes);
    int t = nbytes % 4;
    logic [3:0] ones = 4'b1111;
    return (t == 0) ? ones : 4'(ones << (4 - t));
  endfunction

  task automatic send_frame(input int nbytes, input int nwords, input logic [31:0] base,
                            input int err_word, input bit expect_ok);
    exp_t e;
    for (int w = 0; w < nwords; w++) begin
      rec_data_en  = 1'b1;
      rec_data     = base + 32'(w);
      rec_end      = (w == nwords - 1);
      rec_data_num = 16'(nbytes);
      err_flag     = (w == err_word);
      if (expect_ok) begin
        e.d = base + 32'(w);
        e.l = (w == nwords - 1);
        e.k = (w == nwords - 1) ? model_keep(nbytes) : 4'b1111;
        exp_q.push_back(e);
      end
      @(negedge sys_clk);
    end
    rec_data_en  = 1'b0;
    rec_end      = 1'b0;
    rec_data     = '0;
    rec_data_num = '0;
    err_flag     = 1'b0;
  endtask

  // Consume expected words; a stalled word must stay valid and unchanged.
  task automatic drain(input int max_cycles, input bit rnd);
    int   cyc = 0;
    logic pv  = 1'b0;
    logic pr  = 1'b0;
    exp_t e;
    while (exp_q.size() != 0 && cyc < max_cycles) begin
      if (pv && !pr) check("stall_valid", 32'(m_valid), 32'd1);
      m_ready = rnd ? (($urandom % 4) != 0) : 1'b1;
      if (m_valid) begin
        e = exp_q[0];
        check("word_data", m_data, e.d);
        check("word_last_keep", {27'd0, m_last, m_keep}, {27'd0, e.l, e.k});
        if (m_ready) void'(exp_q.pop_front());
      end
      pv = m_valid;
      pr = m_ready;
      @(negedge sys_clk);
      cyc++;
    end
    check("drain_words_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    m_ready = 1'b1;
    repeat (6) @(negedge sys_clk);
    check("drain_no_extra", 32'(m_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    sys_rst      = 1'b1;
    rec_data_en  = 1'b0;
    rec_data     = '0;
    rec_end      = 1'b0;
    rec_data_num = '0;
    err_flag     = 1'b0;
    m_ready      = 1'b0;
    repeat (2) @(negedge sys_clk);

    // Reset values.
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_m_keep", 32'(m_keep), 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_ok_cnt", 32'(frm_ok_cnt), 32'd0);
    check("rst_drop_cnt", 32'(frm_drop_cnt), 32'd0);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // Clean 10-byte frame: m_valid three edges after the rec_end edge.
    m_ready = 1'b1;
    send_frame(10, 3, 32'hA100_0000, -1, 1'b1);
    check("lat_T0", 32'(m_valid), 32'd0);
    @(negedge sys_clk);
    check("lat_T1", 32'(m_valid), 32'd0);
    @(negedge sys_clk);
    check("lat_T2", 32'(m_valid), 32'd0);
    @(negedge sys_clk);
    check("lat_T3_valid", 32'(m_valid), 32'd1);
    check("lat_T3_data", m_data, 32'hA100_0000);
    drain(100, 1'b0);
    check("clean_ok_cnt", 32'(frm_ok_cnt), 32'd1);
    check("clean_drop_cnt", 32'(frm_drop_cnt), 32'd0);

    // 18-byte frame with err_flag on word 2 is dropped; clean 8-byte follows.
    send_frame(18, 5, 32'hB200_0000, 1, 1'b0);
    send_frame(8, 2, 32'hB300_0000, -1, 1'b1);
    drain(100, 1'b0);
    check("err_drop_cnt", 32'(frm_drop_cnt), 32'd1);
    check("err_ok_cnt", 32'(frm_ok_cnt), 32'd2);

    // Overflow: 20 words into a 16-word buffer while stalled.
    m_ready = 1'b0;
    send_frame(80, 20, 32'hC400_0000, -1, 1'b0);
    check("ovf_drop_cnt", 32'(frm_drop_cnt), 32'd2);
    check("ovf_wr_ptr_rewind", 32'(dut.wr_ptr), 32'd5);
    send_frame(4, 1, 32'hC500_0000, -1, 1'b1);
    repeat (5) @(negedge sys_clk);
    check("ovf_hold_valid", 32'(m_valid), 32'd1);
    check("ovf_hold_data", m_data, 32'hC500_0000);
    check("ovf_hold_last", 32'(m_last), 32'd1);
    drain(100, 1'b0);
    check("ovf_ok_cnt", 32'(frm_ok_cnt), 32'd3);

    // Descriptor full: nine 4-byte frames while stalled, the ninth is dropped.
    m_ready = 1'b0;
    for (int f = 0; f < 9; f++)
      send_frame(4, 1, 32'hD600_0000 + 32'(f), -1, (f < 8));
    check("dfull_ok_cnt", 32'(frm_ok_cnt), 32'd11);
    check("dfull_drop_cnt", 32'(frm_drop_cnt), 32'd3);
    drain(200, 1'b0);

    // Back-to-back replay with random m_ready, three batches across the wrap.
    for (int b = 0; b < 3; b++) begin
      m_ready = 1'b0;
      send_frame(13, 4, 32'hE000_0000 + 32'(b << 12) + 32'h000, -1, 1'b1);
      send_frame(7,  2, 32'hE000_0000 + 32'(b << 12) + 32'h100, -1, 1'b1);
      send_frame(16, 4, 32'hE000_0000 + 32'(b << 12) + 32'h200, -1, 1'b1);
      send_frame(1,  1, 32'hE000_0000 + 32'(b << 12) + 32'h300, -1, 1'b1);
      send_frame(10, 3, 32'hE000_0000 + 32'(b << 12) + 32'h400, -1, 1'b1);
      drain(2000, 1'b1);
    end
    check("wrap_ok_cnt", 32'(frm_ok_cnt), 32'd26);
    check("wrap_drop_cnt", 32'(frm_drop_cnt), 32'd3);

    // Reset mid-stream, then a clean 6-byte frame.
    m_ready = 1'b0;
    send_frame(20, 5, 32'hF700_0000, -1, 1'b0);
    repeat (5) @(negedge sys_clk);
    check("mid_streaming", 32'(m_valid), 32'd1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("mrst_m_valid", 32'(m_valid), 32'd0);
    check("mrst_m_last", 32'(m_last), 32'd0);
    check("mrst_m_keep", 32'(m_keep), 32'd0);
    check("mrst_m_data", m_data, 32'd0);
    check("mrst_ok_cnt", 32'(frm_ok_cnt), 32'd0);
    check("mrst_drop_cnt", 32'(frm_drop_cnt), 32'd0);
    sys_rst = 1'b0;
    m_ready = 1'b1;
    repeat (6) @(negedge sys_clk);
    check("mrst_no_partial", 32'(m_valid), 32'd0);
    send_frame(6, 2, 32'hF800_0000, -1, 1'b1);
    drain(100, 1'b0);
    check("post_rst_ok_cnt", 32'(frm_ok_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
